// File: rtl/csel_pipe_pkg.sv
// csel_pipe_pkg: shared types and configuration helpers for the pipelined carry-select adder
package csel_pipe_pkg;
  typedef struct packed {
    logic sum;
    logic cout;
  } seg_sum_t;
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction
  function automatic int sps(input int width, input int seg, input int stages);
    return width / seg / stages;
  endfunction
  function automatic bit cfg_ok(input int width, input int seg, input int stages);
    return seg >= 1 && stages >= 1 && width % seg == 0 && (width / seg) % stages == 0;
  endfunction
  function automatic seg_sum_t fa(input logic a, input logic b, input logic c);
    return '{sum: a ^ b ^ c, cout: (a & b) | (c & (a ^ b))};
  endfunction
endpackage

// File: rtl/csel_segment.sv
// csel_segment: SEG-bit dual ripple (carry-in 0 and 1) with carry-select output mux
// Ports: a, b (SEG) operands; cin selects the precomputed result; sum (SEG), cout.
module csel_segment
  import csel_pipe_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);
  logic [SEG-1:0] s0, s1;
  logic k0, k1;
  seg_sum_t t0, t1;
  always_comb begin
    k0 = 1'b0;
    k1 = 1'b1;
    s0 = '0;
    s1 = '0;
    t0 = '0;
    t1 = '0;
    for (int i = 0; i < SEG; i++) begin
      t0 = fa(a[i], b[i], k0);
      t1 = fa(a[i], b[i], k1);
      s0[i] = t0.sum;
      s1[i] = t1.sum;
      k0 = t0.cout;
      k1 = t1.cout;
    end
  end
  assign sum  = cin ? s1 : s0;
  assign cout = cin ? k1 : k0;
endmodule

// File: rtl/csel_pipe_adder.sv
// csel_pipe_adder: pipelined carry-select adder/subtractor with valid/ready handshake
// Ports: clk, rst (sync, active-high); in_valid/in_ready, in_a, in_b, in_cin, in_sub;
//        out_valid/out_ready, out_sum, out_cout, out_ovf.
// Optional: define CSEL_PIPE_SAT_EN to saturate out_sum on signed overflow.
module csel_pipe_adder
  import csel_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SEG    = 4,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NSEG = nseg(WIDTH, SEG);
  localparam int SPS  = sps(WIDTH, SEG, STAGES);
  localparam int SB   = SPS * SEG;
  localparam int L    = STAGES - 1;
  if (!cfg_ok(WIDTH, SEG, STAGES) || NSEG < STAGES) begin : g_cfg_err
    $error("csel_pipe_adder: WIDTH must be a multiple of SEG and WIDTH/SEG a multiple of STAGES");
  end
  logic adv, ovf_d, ovf_q;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SB;
    // pa/pb hold only the operand bits not yet consumed by earlier stages
    logic [WIDTH-1:LO]   pa, pb;
    logic [LO+SB-1:0]    s_d, s_q;
    logic [SB-1:0]       ss;
    logic [SPS:0]        ch;
    logic                pc, pv, c_q, v_q;
    if (k == 0) begin : g_head
      assign pa  = in_a;
      assign pb  = in_sub ? ~in_b : in_b;
      assign pc  = in_sub | in_cin;
      assign pv  = in_valid;
      assign s_d = ss;
    end else begin : g_body
      assign pa  = g_st[k-1].g_op.a_q;
      assign pb  = g_st[k-1].g_op.b_q;
      assign pc  = g_st[k-1].c_q;
      assign pv  = g_st[k-1].v_q;
      assign s_d = {ss, g_st[k-1].s_q};
    end
    assign ch[0] = pc;
    for (genvar j = 0; j < SPS; j++) begin : g_seg
      csel_segment #(.SEG(SEG)) u_seg (
        .a   (pa[LO+j*SEG +: SEG]),
        .b   (pb[LO+j*SEG +: SEG]),
        .cin (ch[j]),
        .sum (ss[j*SEG +: SEG]),
        .cout(ch[j+1])
      );
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= pv;
        c_q <= ch[SPS];
        s_q <= s_d;
      end
    end
    if (k < L) begin : g_op
      logic [WIDTH-1:LO+SB] a_q, b_q;
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= pa[WIDTH-1:LO+SB];
          b_q <= pb[WIDTH-1:LO+SB];
        end
      end
    end
  end
  assign ovf_d = (g_st[L].pa[WIDTH-1] == g_st[L].pb[WIDTH-1]) &
                 (g_st[L].s_d[WIDTH-1] != g_st[L].pa[WIDTH-1]);
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end
  assign out_valid = g_st[L].v_q;
  assign out_cout  = g_st[L].c_q;
  assign out_ovf   = ovf_q;
`ifdef CSEL_PIPE_SAT_EN
  // On overflow the wrapped sign is the inverse of the true sign, so it picks the rail directly
  logic msb;
  assign msb     = g_st[L].s_q[WIDTH-1];
  assign out_sum = ovf_q ? {~msb, {(WIDTH-1){msb}}} : g_st[L].s_q;
`else
  assign out_sum = g_st[L].s_q;
`endif
endmodule
